// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer for a 6-stage pipeline.
// Combinational per-stage stall mask from the stage requests, a one-cycle
// registered flush/redirect on exceptions (deferred while memory is stalled),
// and a saturating stall-cycle counter.
// Optional stall watchdog enabled by defining STALL_WATCHDOG_EN.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_RUN   | pipeline flowing, no stall seen on the previous edge
// ST_STALL | at least one stage requested a hold on the previous edge
// ST_PEND  | exception accepted while memory stalled; waiting for mem to free
// ST_FLUSH | single cycle: flush=1, new_pc=latched target, stall forced to 0
module pipeline_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        stallreq_id,
   input  logic        stallreq_ex,
   input  logic        stallreq_mem,
   input  logic        excp_valid,
   input  logic [31:0] excp_handler,
   output logic [5:0]  stall,
   output logic        flush,
   output logic [31:0] new_pc,
   output logic [15:0] stall_cnt,
   output logic        wdog_err
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_STALL = 2'd1,
      ST_PEND  = 2'd2,
      ST_FLUSH = 2'd3
   } state_t;

   localparam logic [31:0] WDOG_VEC = 32'hBFC0_0380;

   state_t      state_q, state_d;
   logic [31:0] handler_q, handler_d;
   logic        flush_q, flush_d;
   logic [31:0] new_pc_q, new_pc_d;
   logic [15:0] stall_cnt_q, stall_cnt_d;
   logic [5:0]  req_vec;
   logic        any_req;
   logic        wdog_fire;

   // Highest requesting stage wins; it holds itself and everything upstream.
   always_comb begin
      req_vec = 6'b000000;
      if (stallreq_mem) begin
         req_vec = 6'b011111;
      end else if (stallreq_ex) begin
         req_vec = 6'b001111;
      end else if (stallreq_id) begin
         req_vec = 6'b000111;
      end
   end

   assign any_req = stallreq_id | stallreq_ex | stallreq_mem;

`ifdef STALL_WATCHDOG_EN
   logic [9:0] wdog_cnt_q, wdog_cnt_d;
   logic       wdog_err_q, wdog_err_d;
   logic       in_hold;

   // Count consecutive cycles spent holding (STALL or PEND); fire at 1023.
   always_comb begin
      in_hold    = (state_q == ST_STALL) || (state_q == ST_PEND);
      wdog_cnt_d = in_hold ? wdog_cnt_q + 10'd1 : 10'd0;
      wdog_fire  = in_hold && (wdog_cnt_q == 10'd1023);
      wdog_err_d = wdog_err_q | wdog_fire;
   end

   // Watchdog counter and sticky error flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wdog_cnt_q <= 10'd0;
         wdog_err_q <= 1'b0;
      end else begin
         wdog_cnt_q <= wdog_cnt_d;
         wdog_err_q <= wdog_err_d;
      end
   end

   assign wdog_err = wdog_err_q;
`else
   assign wdog_fire = 1'b0;
   assign wdog_err  = 1'b0;
`endif

   // State, latched handler and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_RUN;
         handler_q   <= 32'h0;
         flush_q     <= 1'b0;
         new_pc_q    <= 32'h0;
         stall_cnt_q <= 16'h0;
      end else begin
         state_q     <= state_d;
         handler_q   <= handler_d;
         flush_q     <= flush_d;
         new_pc_q    <= new_pc_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   // Next state; the handler is captured only when an exception is accepted,
   // so later pulses in PEND/FLUSH cannot overwrite it.
   always_comb begin
      state_d   = state_q;
      handler_d = handler_q;
      if (wdog_fire) begin
         state_d   = ST_FLUSH;
         handler_d = WDOG_VEC;
      end else begin
         case (state_q)
            ST_RUN, ST_STALL: begin
               if (excp_valid) begin
                  handler_d = excp_handler;
                  state_d   = stallreq_mem ? ST_PEND : ST_FLUSH;
               end else if (any_req) begin
                  state_d = ST_STALL;
               end else begin
                  state_d = ST_RUN;
               end
            end
            ST_PEND: begin
               if (!stallreq_mem) begin
                  state_d = ST_FLUSH;
               end
            end
            ST_FLUSH: state_d = ST_RUN;
            default:  state_d = ST_RUN;
         endcase
      end
   end

   // Outputs: stall is zero-latency from the requests (masked in FLUSH and
   // reset); flush/new_pc are precomputed from the next state.
   always_comb begin
      stall = 6'b000000;
      if (rst && (state_q != ST_FLUSH)) begin
         stall = req_vec;
      end
      flush_d     = (state_d == ST_FLUSH);
      new_pc_d    = flush_d ? handler_d : 32'h0;
      stall_cnt_d = stall_cnt_q;
      if ((stall != 6'b000000) && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   assign flush     = flush_q;
   assign new_pc    = new_pc_q;
   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios plus random traffic, all checked
// every cycle against a behavioural model, with literal pins on key scenarios.
module tb_pipeline_ctrl;

`ifdef STALL_WATCHDOG_EN
   localparam bit WD = 1'b1;
`else
   localparam bit WD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        i_id = 1'b0, i_ex = 1'b0, i_mem = 1'b0, i_ev = 1'b0;
   logic [31:0] i_h = 32'h0;
   logic [5:0]  stall;
   logic        flush;
   logic [31:0] new_pc;
   logic [15:0] stall_cnt;
   logic        wdog_err;

   pipeline_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .stallreq_id  (i_id),
      .stallreq_ex  (i_ex),
      .stallreq_mem (i_mem),
      .excp_valid   (i_ev),
      .excp_handler (i_h),
      .stall        (stall),
      .flush        (flush),
      .new_pc       (new_pc),
      .stall_cnt    (stall_cnt),
      .wdog_err     (wdog_err)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;

   // model state
   bit          m_flush;
   logic [31:0] m_addr;
   bit          m_pend;
   logic [31:0] m_ph;
   int          m_cnt;
   bit          m_wdog;
   bit          m_hold;
   int          m_run;

   // last sampled DUT outputs
   logic [5:0]  s_stall;
   logic        s_flush;
   logic [31:0] s_new_pc;
   logic [15:0] s_cnt;
   logic        s_wdog;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [5:0] prio(input logic id, input logic ex, input logic mem);
      if (mem) return 6'b011111;
      if (ex)  return 6'b001111;
      if (id)  return 6'b000111;
      return 6'b000000;
   endfunction

   task automatic model_reset();
      m_flush = 0; m_addr = 0; m_pend = 0; m_ph = 0;
      m_cnt = 0; m_wdog = 0; m_hold = 0; m_run = 0;
   endtask

   // Advance the model across one active edge using the inputs of this cycle.
   task automatic model_step();
      bit any, fl_n, p_n, h_n, fire;
      logic [31:0] a_n, ph_n;
      any = i_id | i_ex | i_mem;
      if (!m_flush && any && m_cnt < 65535) m_cnt++;
      fl_n = 0; a_n = 0; p_n = m_pend; ph_n = m_ph;
      fire = WD && m_hold && (m_run == 1023);
      if (fire) begin
         fl_n = 1; a_n = 32'hBFC00380; p_n = 0; m_wdog = 1;
      end else if (m_flush) begin
         fl_n = 0;
      end else if (m_pend) begin
         if (!i_mem) begin fl_n = 1; a_n = m_ph; p_n = 0; end
      end else if (i_ev) begin
         if (i_mem) begin p_n = 1; ph_n = i_h; end
         else begin fl_n = 1; a_n = i_h; end
      end
      h_n = !fl_n && (p_n || (!m_flush && !m_pend && !i_ev && any));
      m_run  = (h_n && m_hold) ? m_run + 1 : 0;
      m_hold = h_n;
      m_flush = fl_n; m_addr = a_n; m_pend = p_n; m_ph = ph_n;
   endtask

   task automatic sample_and_compare();
      s_stall = stall; s_flush = flush; s_new_pc = new_pc; s_cnt = stall_cnt; s_wdog = wdog_err;
      chk("stall",     32'(s_stall),  32'((!rst || m_flush) ? 6'b0 : prio(i_id, i_ex, i_mem)));
      chk("flush",     32'(s_flush),  32'(m_flush));
      chk("new_pc",    s_new_pc,      m_flush ? m_addr : 32'h0);
      chk("stall_cnt", 32'(s_cnt),    32'(m_cnt));
      chk("wdog_err",  32'(s_wdog),   32'(m_wdog));
   endtask

   // Called at a negedge: drive, check, cross the posedge, return at next negedge.
   task automatic do_cycle(input logic id, input logic ex, input logic mem,
                           input logic ev, input logic [31:0] h);
      i_id = id; i_ex = ex; i_mem = mem; i_ev = ev; i_h = h;
      #1;
      sample_and_compare();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   // Called at a negedge: assert reset for one edge, release at the next negedge.
   task automatic do_reset(input logic mem);
      rst = 1'b0;
      i_id = 0; i_ex = 0; i_mem = mem; i_ev = 0; i_h = 32'h0;
      model_reset();
      #1;
      sample_and_compare();
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      #50_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int nflush, first_fl;
      logic [31:0] fl_pc;
      model_reset();
      @(negedge clk);
      do_reset(1'b0);

      // Model pins: reset values
      chk("rst_stall_cnt", 32'(s_cnt), 32'h0);
      chk("rst_flush", 32'(s_flush), 32'h0);

      // ex stall for 3 cycles
      for (int k = 0; k < 3; k++) begin
         do_cycle(0, 1, 0, 0, 32'h0);
         chk("ex_stall", 32'(s_stall), 32'h0F);
      end
      do_cycle(0, 0, 0, 0, 32'h0);
      chk("ex_cnt3", 32'(s_cnt), 32'd3);

      // id + mem together
      do_cycle(1, 0, 1, 0, 32'h0);
      chk("id_mem_stall", 32'(s_stall), 32'h1F);
      do_cycle(0, 0, 0, 0, 32'h0);
      do_cycle(0, 0, 0, 0, 32'h0);

      // plain exception, flush cycle masks a concurrent ex request
      do_cycle(0, 0, 0, 1, 32'h80000180);
      chk("exc_noflush_yet", 32'(s_flush), 32'h0);
      do_cycle(0, 1, 0, 0, 32'h0);
      chk("exc_flush", 32'(s_flush), 32'h1);
      chk("exc_new_pc", s_new_pc, 32'h80000180);
      chk("exc_stall0", 32'(s_stall), 32'h0);
      do_cycle(0, 0, 0, 0, 32'h0);
      chk("exc_flush_off", 32'(s_flush), 32'h0);
      chk("exc_pc_off", s_new_pc, 32'h0);
      do_cycle(0, 0, 0, 0, 32'h0);

      // deferred exception under mem stall, second pulse ignored
      nflush = 0; first_fl = -1; fl_pc = 32'h0;
      for (int c = 0; c < 10; c++) begin
         do_cycle(0, 0, (c < 5), (c == 1) || (c == 3),
                  (c == 1) ? 32'h80000200 : 32'h0);
         if (s_flush) begin
            nflush++;
            if (first_fl < 0) begin first_fl = c; fl_pc = s_new_pc; end
         end
      end
      chk("pend_nflush", 32'(nflush), 32'd1);
      chk("pend_flush_at", 32'(first_fl), 32'd6);
      chk("pend_new_pc", fl_pc, 32'h80000200);

      // reset while in PEND discards the exception
      do_cycle(0, 0, 1, 1, 32'h80000300);
      do_cycle(0, 0, 1, 0, 32'h0);
      do_reset(1'b1);
      chk("pendrst_stall", 32'(s_stall), 32'h0);
      chk("pendrst_flush", 32'(s_flush), 32'h0);
      chk("pendrst_pc", s_new_pc, 32'h0);
      chk("pendrst_cnt", 32'(s_cnt), 32'h0);
      nflush = 0;
      for (int c = 0; c < 6; c++) begin
         do_cycle(0, 0, 0, 0, 32'h0);
         if (s_flush) nflush++;
      end
      chk("pendrst_noflush", 32'(nflush), 32'd0);

      // watchdog: hold mem continuously
      do_reset(1'b0);
      first_fl = -1; fl_pc = 32'h0;
      for (int c = 0; c < 1100; c++) begin
         do_cycle(0, 0, 1, 0, 32'h0);
         if (s_flush && first_fl < 0) begin first_fl = c; fl_pc = s_new_pc; end
      end
`ifdef STALL_WATCHDOG_EN
      chk("wdog_flush_at", 32'(first_fl), 32'd1025);
      chk("wdog_pc", fl_pc, 32'hBFC00380);
      chk("wdog_err_set", 32'(s_wdog), 32'h1);
`else
      chk("wdog_no_flush", 32'(first_fl), 32'hFFFFFFFF);
      chk("wdog_err_zero", 32'(s_wdog), 32'h0);
`endif

      // saturation of stall_cnt
      do_reset(1'b0);
      for (int c = 0; c < 70000; c++) do_cycle(1, 0, 0, 0, 32'h0);
      chk("cnt_saturated", 32'(s_cnt), 32'hFFFF);
      do_cycle(1, 0, 0, 0, 32'h0);
      chk("cnt_held", 32'(s_cnt), 32'hFFFF);

      // random traffic with occasional resets
      do_reset(1'b0);
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 199) == 0) begin
            do_reset(1'($urandom_range(0, 1)));
         end else begin
            do_cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
                     ($urandom_range(0, 3) == 0), ($urandom_range(0, 11) == 0),
                     $urandom);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
